layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Controller that time-shares one layer datapath (MAC accumulator, bias adder, activation stage) across all neurons of a fully connected layer. On `start` it walks every neuron and every input index: it drives input and weight addresses, issues req/ack transactions to each datapath stage in order, and strobes the activated result into the output register file. It sits between the network-level controller and the layer datapath, replacing per-neuron hardwired MAC instances.

## Interface
- `N_IN`, default 2: inputs per neuron, ≥1.
- `N_OUT`, default 2: neurons in the layer, ≥1.
- `IW`, default `$clog2(N_IN)` (min 1): width of the input index.
- `OW`, default `$clog2(N_OUT)` (min 1): width of the neuron index.
- `WW`, default `$clog2(N_IN*N_OUT)` (min 1): width of the weight address.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: begin a layer pass; honoured only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the pass completes.
- `in_idx` out IW: input operand select.
- `out_idx` out OW: current neuron.
- `w_addr` out WW: weight address, equal to `out_idx*N_IN + in_idx`.
- `mac_clr` out 1: one-cycle pulse that clears the accumulator.
- `mac_req` / `mac_ack`, out/in, 1 each: multiply-accumulate handshake.
- `bias_req` / `bias_ack`, out/in, 1 each: bias-add handshake; bias address is `out_idx`.
- `act_req` / `act_ack`, out/in, 1 each: activation handshake.
- `out_we` out 1: one-cycle write strobe for the activated value at `out_idx`.
- `proto_err` out 1: sticky flag for an ack received with no matching req.

## Operation
- States: IDLE, CLEAR, MAC_REQ, MAC_GAP, BIAS_REQ, BIAS_GAP, ACT_REQ, ACT_GAP, WRITE, DONE.
- IDLE: if `start`=1, clear `in_idx`/`out_idx`/`proto_err` and go to CLEAR. Otherwise stay.
- CLEAR: `mac_clr`=1 → MAC_REQ.
- MAC_REQ: `mac_req`=1, held until `mac_ack`=1 → MAC_GAP.
- MAC_GAP: all reqs low.
  - If `in_idx`=N_IN-1: set `in_idx`=0 → BIAS_REQ.
  - Else: increment `in_idx` → MAC_REQ.
- BIAS_REQ: hold `bias_req` until `bias_ack` → BIAS_GAP → ACT_REQ.
- ACT_REQ: hold `act_req` until `act_ack` → ACT_GAP → WRITE.
- WRITE: `out_we`=1.
  - If `out_idx`=N_OUT-1 → DONE.
  - Else: increment `out_idx` → CLEAR.
- DONE: `done`=1 → IDLE. `out_idx` and `in_idx` return to 0.
- Return-to-zero handshake: each req is low for at least one cycle (the GAP state) between transactions. Addresses are stable for the whole req-high window and the following GAP cycle.
- At most one req is high in any cycle.
- An ack while its own req is low sets `proto_err`, and the ack is otherwise ignored. `proto_err` is cleared only by reset or by an accepted `start`.
- `start` while busy is ignored; no queuing.
- Index arithmetic is unsigned. Wrap happens only via the explicit compares above; indices never exceed N-1.
- Datapath interfaces are combinational, Moore outputs decoded from state. Acks are sampled on posedge.

## Timing
- Reset (`rst`=0 at a posedge): state IDLE. The next cycle after reset has `busy`, `done`, `mac_clr`, all reqs, `out_we`, `proto_err` = 0, and `in_idx`, `out_idx`, `w_addr` = 0.
- Reset mid-pass aborts immediately: no `done`, no further `out_we`.
- Let k ≥ 1 be the number of cycles a req is high, including the ack cycle.
  - k=1 means a combinational ack in the first req cycle.
- Each transaction costs k+1 cycles.
- Per neuron: 1 + (N_IN+2)(k+1) + 1 cycles.
- `start` sampled at edge 0 → CLEAR in cycle 1.
- `done` is in cycle N_OUT·(2 + (N_IN+2)(k+1)) + 1.
- `busy` falls in the cycle after `done`.
- `start` asserted in the same cycle as `done` is ignored. `start` in the first IDLE cycle is accepted.

## Test plan
- Reset/idle: hold `rst`=0 for 3 cycles, then release with `start`=0 → all outputs 0 and `busy` stays 0 for 10 cycles.
- Nominal pass, N_IN=2, N_OUT=2, combinational acks (k=1), `start` at cycle 0 → `mac_clr` in cycles 1 and 11, `out_we` in cycles 10 and 20, `done` in cycle 21.
  - `w_addr` sequence: 0, 1, 2, 3.
  - `out_idx` at the two `out_we` strobes: 0, then 1.
- Slow datapath, k=3 on every ack, same parameters → `done` in cycle 2·(2+4·4)+1 = 37.
  - Each req is held exactly 3 cycles.
  - `w_addr` is stable throughout each req.
- Spurious `bias_ack` pulse during MAC_REQ → `proto_err`=1 and the sequence is unaltered.
  - `proto_err` stays 1 through `done`.
  - `proto_err` clears on the next accepted `start`.
- Reset mid-operation: `rst`=0 for one cycle while in ACT_REQ of neuron 0 → IDLE next cycle, no `out_we`, no `done`.
  - A subsequent `start` produces the full nominal sequence.
- `start` pulsed while busy, and again in the `done` cycle → both ignored.
  - `start` one cycle later begins a new pass, with `mac_clr` the following cycle.

Source files
------------

// File: rtl/layer_sequencer.sv
// Walks every neuron/input of a fully connected layer through one shared MAC/bias/activation datapath.
// Each stage is a return-to-zero req/ack handshake held until ack; start is ignored while busy.
module layer_sequencer #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int IW    = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  parameter int WW    = ((N_IN * N_OUT) > 1) ? $clog2(N_IN * N_OUT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] in_idx,
  output logic [OW-1:0] out_idx,
  output logic [WW-1:0] w_addr,
  output logic          mac_clr,
  output logic          mac_req,
  input  logic          mac_ack,
  output logic          bias_req,
  input  logic          bias_ack,
  output logic          act_req,
  input  logic          act_ack,
  output logic          out_we,
  output logic          proto_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_MAC_REQ, S_MAC_GAP, S_BIAS_REQ,
    S_BIAS_GAP, S_ACT_REQ, S_ACT_GAP, S_WRITE, S_DONE
  } state_t;

  localparam logic [IW-1:0] IN_LAST  = IW'(N_IN - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(N_OUT - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] in_idx_q, in_idx_d;
  logic [OW-1:0] out_idx_q, out_idx_d;
  logic          proto_err_q, proto_err_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      in_idx_q    <= '0;
      out_idx_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_idx_q    <= in_idx_d;
      out_idx_q   <= out_idx_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_idx_d    = in_idx_q;
    out_idx_d   = out_idx_q;
    proto_err_d = proto_err_q;
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    mac_clr     = 1'b0;
    mac_req     = 1'b0;
    bias_req    = 1'b0;
    act_req     = 1'b0;
    out_we      = 1'b0;

    // An ack is only legal in the cycle its own req is driven high.
    if ((mac_ack  && state_q != S_MAC_REQ)  ||
        (bias_ack && state_q != S_BIAS_REQ) ||
        (act_ack  && state_q != S_ACT_REQ)) begin
      proto_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_idx_d    = '0;
          out_idx_d   = '0;
          proto_err_d = 1'b0;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        mac_clr = 1'b1;
        state_d = S_MAC_REQ;
      end
      S_MAC_REQ: begin
        mac_req = 1'b1;
        if (mac_ack) state_d = S_MAC_GAP;
      end
      S_MAC_GAP: begin
        if (in_idx_q == IN_LAST) begin
          in_idx_d = '0;
          state_d  = S_BIAS_REQ;
        end else begin
          in_idx_d = in_idx_q + IW'(1);
          state_d  = S_MAC_REQ;
        end
      end
      S_BIAS_REQ: begin
        bias_req = 1'b1;
        if (bias_ack) state_d = S_BIAS_GAP;
      end
      S_BIAS_GAP: state_d = S_ACT_REQ;
      S_ACT_REQ: begin
        act_req = 1'b1;
        if (act_ack) state_d = S_ACT_GAP;
      end
      S_ACT_GAP: state_d = S_WRITE;
      S_WRITE: begin
        out_we = 1'b1;
        if (out_idx_q == OUT_LAST) begin
          state_d = S_DONE;
        end else begin
          out_idx_d = out_idx_q + OW'(1);
          state_d   = S_CLEAR;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        in_idx_d  = '0;
        out_idx_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_idx    = in_idx_q;
  assign out_idx   = out_idx_q;
  assign w_addr    = WW'(out_idx_q) * WW'(N_IN) + WW'(in_idx_q);
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer (N_IN=2, N_OUT=2) with a k-cycle ack responder.
module tb_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst, start;
  logic       busy, done, mac_clr, mac_req, mac_ack, bias_req, bias_ack;
  logic       act_req, act_ack, out_we, proto_err;
  logic [0:0] in_idx, out_idx;
  logic [1:0] w_addr;

  always #5 clk = ~clk;

  layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_idx(in_idx), .out_idx(out_idx), .w_addr(w_addr), .mac_clr(mac_clr),
    .mac_req(mac_req), .mac_ack(mac_ack), .bias_req(bias_req), .bias_ack(bias_ack),
    .act_req(act_req), .act_ack(act_ack), .out_we(out_we), .proto_err(proto_err)
  );

  // Datapath responder: ack arrives in the k-th cycle of each req (k=1 is combinational).
  int   k = 1;
  int   cnt = 0;
  logic any_req, ack_now;
  logic sp_bias = 1'b0;
  assign any_req  = mac_req | bias_req | act_req;
  assign ack_now  = any_req && (cnt == k - 1);
  assign mac_ack  = mac_req & ack_now;
  assign bias_ack = (bias_req & ack_now) | sp_bias;
  assign act_ack  = act_req & ack_now;
  always @(posedge clk) begin
    if (any_req && !ack_now) cnt <= cnt + 1;
    else cnt <= 0;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Per-pass observations, cycle numbers relative to the start cycle (0).
  int          clr_c[$], we_c[$], we_oi[$], wa[$], rl[$];
  int          done_c, unstable, multi, len, hold_addr;
  logic        proto_done, proto_c1, busy_rst, busy_after;
  logic [31:0] idx_after;

  task automatic run_pass(input int k_i, input int sp_c, input int rst_c,
                          input int st1, input int st2, input int limit);
    clr_c.delete(); we_c.delete(); we_oi.delete(); wa.delete(); rl.delete();
    done_c = -1; unstable = 0; multi = 0; len = 0; hold_addr = 0;
    proto_done = 1'bx; proto_c1 = 1'bx; busy_rst = 1'bx; busy_after = 1'bx;
    idx_after = 'x;
    k = k_i;
    start = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (mac_clr) clr_c.push_back(c);
      if (out_we) begin
        we_c.push_back(c);
        we_oi.push_back(int'(out_idx));
      end
      if (done) begin
        done_c     = c;
        proto_done = proto_err;
      end
      if (c == 1) proto_c1 = proto_err;
      if (c == rst_c + 1) busy_rst = busy;
      if (done_c >= 0 && c == done_c + 1) begin
        busy_after = busy;
        idx_after  = 32'(in_idx) | 32'(out_idx) | 32'(w_addr);
      end
      if ((int'(mac_req) + int'(bias_req) + int'(act_req)) > 1) multi++;
      if (any_req) begin
        if (len == 0) begin
          hold_addr = int'(w_addr);
          if (mac_req) wa.push_back(int'(w_addr));
        end else if (int'(w_addr) != hold_addr) unstable++;
        len++;
      end else begin
        if (len > 0) begin
          rl.push_back(len);
          if (int'(w_addr) != hold_addr) unstable++;
        end
        len = 0;
      end
      start   = (c == st1 || c == st2);
      sp_bias = (c == sp_c);
      rst     = (c == rst_c) ? 1'b0 : 1'b1;
      if (done_c >= 0 && c == done_c + 1) break;
    end
    start = 1'b0;
  endtask

  initial begin
    int busy_hi;
    int bad_len;
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_mac_clr", 32'(mac_clr), 0);
    check("rst_mac_req", 32'(mac_req), 0);
    check("rst_bias_req", 32'(bias_req), 0);
    check("rst_act_req", 32'(act_req), 0);
    check("rst_out_we", 32'(out_we), 0);
    check("rst_proto_err", 32'(proto_err), 0);
    check("rst_in_idx", 32'(in_idx), 0);
    check("rst_out_idx", 32'(out_idx), 0);
    check("rst_w_addr", 32'(w_addr), 0);
    busy_hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_hi++;
    end
    check("idle_busy_cycles", busy_hi, 0);

    // Nominal pass, combinational acks.
    run_pass(1, -1, -1, -1, -1, 40);
    check("nom_clr_cnt", clr_c.size(), 2);
    check("nom_clr0", qat(clr_c, 0), 1);
    check("nom_clr1", qat(clr_c, 1), 11);
    check("nom_we0", qat(we_c, 0), 10);
    check("nom_we1", qat(we_c, 1), 20);
    check("nom_we_oi0", qat(we_oi, 0), 0);
    check("nom_we_oi1", qat(we_oi, 1), 1);
    check("nom_done", done_c, 21);
    check("nom_wa_cnt", wa.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("nom_waddr%0d", i), qat(wa, i), i);
    check("nom_multi_req", multi, 0);
    check("nom_busy_after", 32'(busy_after), 0);
    check("nom_idx_after", idx_after, 0);
    check("nom_proto", 32'(proto_done), 0);

    // Slow datapath, every req held three cycles.
    run_pass(3, -1, -1, -1, -1, 60);
    bad_len = 0;
    foreach (rl[i]) if (rl[i] != 3) bad_len++;
    check("slow_done", done_c, 37);
    check("slow_req_cnt", rl.size(), 8);
    check("slow_req_len", bad_len, 0);
    check("slow_addr_stable", unstable, 0);
    check("slow_wa2", qat(wa, 2), 2);
    check("slow_we1", qat(we_c, 1), 36);

    // Stray bias_ack during the first MAC_REQ (cycle 2).
    run_pass(1, 2, -1, -1, -1, 40);
    check("sp_done", done_c, 21);
    check("sp_we1", qat(we_c, 1), 20);
    check("sp_wa3", qat(wa, 3), 3);
    check("sp_proto_at_done", 32'(proto_done), 1);
    check("sp_proto_after", 32'(proto_err), 1);

    // Next accepted start clears the sticky flag.
    run_pass(1, -1, -1, -1, -1, 40);
    check("clr_proto_c1", 32'(proto_c1), 0);
    check("clr_done", done_c, 21);

    // Reset while neuron 0 is in ACT_REQ (cycle 8).
    run_pass(1, -1, 8, -1, -1, 30);
    check("abort_busy", 32'(busy_rst), 0);
    check("abort_we_cnt", we_c.size(), 0);
    check("abort_done", done_c, -1);

    run_pass(1, -1, -1, -1, -1, 40);
    check("post_abort_clr1", qat(clr_c, 1), 11);
    check("post_abort_we0", qat(we_c, 0), 10);
    check("post_abort_done", done_c, 21);

    // Start pulses while busy (cycle 5) and in the done cycle are dropped.
    run_pass(1, -1, -1, 5, 21, 40);
    check("ign_clr_cnt", clr_c.size(), 2);
    check("ign_clr1", qat(clr_c, 1), 11);
    check("ign_done", done_c, 21);
    check("ign_busy_after", 32'(busy_after), 0);

    // Start in the first IDLE cycle is taken.
    run_pass(1, -1, -1, -1, -1, 40);
    check("restart_clr0", qat(clr_c, 0), 1);
    check("restart_done", done_c, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
